// File: rtl/rf_writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_wb_pkg
//  Description : Shared definitions for the register-file writeback unit:
//                load funct3 encodings and the queued writeback entry type.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_wb_pkg;

    // Widths baked into the queued entry type; the top-level XLEN/RA_W
    // parameters must keep these values.
    localparam int WB_XLEN = 32;
    localparam int WB_RA_W = 5;

    // Load funct3 encodings
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef struct packed {
        logic [WB_RA_W-1:0] addr;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_unit_if
//  Description : Bundle of the writeback unit's producer handshakes (ALU, LSU),
//                register-file write port and status outputs.
//                slave  : the writeback unit itself
//                master : the surrounding pipeline / register file
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_writeback_unit_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    // ALU producer
    logic            alu_valid_i;
    logic            alu_ready_o;
    logic [RA_W-1:0] alu_addr_i;
    logic [XLEN-1:0] alu_data_i;
    // LSU producer (load responses)
    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [RA_W-1:0] lsu_addr_i;
    logic [2:0]      lsu_funct3_i;
    logic [1:0]      lsu_off_i;
    logic [XLEN-1:0] lsu_data_i;
    // Register-file write port
    logic            rf_we_o;
    logic [RA_W-1:0] rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    // Status
    logic [31:0]     pending_o;
    logic            busy_o;

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  lsu_valid_i, lsu_addr_i, lsu_funct3_i, lsu_off_i, lsu_data_i,
        output alu_ready_o, lsu_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, pending_o, busy_o
    );

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output lsu_valid_i, lsu_addr_i, lsu_funct3_i, lsu_off_i, lsu_data_i,
        input  alu_ready_o, lsu_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, pending_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/rf_writeback_unit_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : In-order circular buffer with two write ports and one read
//                port. Port 0 is the older entry when both write in the same
//                cycle. Exposes occupancy plus per-slot valid/addr so the
//                parent can build a pending-register mask.
//  Ports       : clk_i, rst_i        clock, synchronous active-high reset
//                push0_i/entry0_i    older write port
//                push1_i/entry1_i    younger write port
//                pop_i               drop head (ignored when empty)
//                head_o, count_o     head entry and occupancy
//                valid_o, addr_o     per-slot valid flag and destination
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            push0_i,
    input  wb_entry_t                       entry0_i,
    input  logic                            push1_i,
    input  wb_entry_t                       entry1_i,
    input  logic                            pop_i,
    output wb_entry_t                       head_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic [DEPTH-1:0]                valid_o,
    output logic [DEPTH-1:0][WB_RA_W-1:0]   addr_o
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;

    logic             w_pop;
    logic [c_CW-1:0]  w_npush;
    logic [c_PW-1:0]  w_wptr1;

    assign w_pop   = pop_i && (r_count != '0);
    assign w_npush = c_CW'(push0_i) + c_CW'(push1_i);
    assign w_wptr1 = r_wptr + c_PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + c_PW'(w_npush);
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            r_count <= r_count + w_npush - c_CW'(w_pop);
        end
    end

    // Storage needs no reset; slot validity is derived from the pointers.
    // A lone push1 lands in the first free slot just like push0 would.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (push0_i) begin
                r_mem[r_wptr] <= entry0_i;
            end
            if (push1_i) begin
                r_mem[push0_i ? w_wptr1 : r_wptr] <= entry1_i;
            end
        end
    end

    assign head_o  = r_mem[r_rptr];
    assign count_o = r_count;

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [c_PW-1:0] w_rel;
        assign w_rel      = c_PW'(i) - r_rptr;
        assign valid_o[i] = ({1'b0, w_rel} < r_count);
        assign addr_o[i]  = r_mem[i].addr;
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        r_count <= c_CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/rf_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_unit
//  Description : Initiator side of the register-file write port. Accepts ALU
//                and LSU results through valid/ready handshakes (LSU has
//                priority and is older on a simultaneous accept), extends
//                load data, queues entries in order and drains one write per
//                cycle. Exports a pending-write mask for decode stalls.
//  Ports       : clk_i  clock
//                rst_i  synchronous reset, active-high
//                wb     rf_writeback_unit_if.slave (producers, RF port, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback_unit
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = WB_XLEN,
    parameter int RA_W  = WB_RA_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rf_writeback_unit_if.slave   wb
);
    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam int c_FW = c_CW + 1;

    // Sign/zero extension of a load from an aligned memory word.
    function automatic logic [XLEN-1:0] f_load_ext(
        input logic [2:0]      funct3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  v_b;
        logic [15:0] v_h;
        case (off)
            2'd0:    v_b = word[7:0];
            2'd1:    v_b = word[15:8];
            2'd2:    v_b = word[23:16];
            default: v_b = word[31:24];
        endcase
        v_h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            LDST_B:  f_load_ext = {{(XLEN-8){v_b[7]}}, v_b};
            LDST_BU: f_load_ext = {{(XLEN-8){1'b0}}, v_b};
            LDST_H:  f_load_ext = {{(XLEN-16){v_h[15]}}, v_h};
            LDST_HU: f_load_ext = {{(XLEN-16){1'b0}}, v_h};
            default: f_load_ext = word;
        endcase
    endfunction

    wb_entry_t                      w_lsu_entry;
    wb_entry_t                      w_alu_entry;
    wb_entry_t                      w_head;
    logic [c_CW-1:0]                w_count;
    logic [DEPTH-1:0]               w_valid;
    logic [DEPTH-1:0][WB_RA_W-1:0]  w_addr;
    logic [c_FW-1:0]                w_free;
    logic                           w_lsu_ready;
    logic                           w_alu_ready;
    logic                           w_lsu_push;
    logic                           w_alu_push;
    logic                           w_busy;
    logic [31:0]                    w_pending;

    // The head slot is freed at the same edge it is written out, so a
    // non-empty queue offers one extra slot.
    assign w_free = c_FW'(DEPTH) - c_FW'(w_count) + c_FW'(w_count != '0);

    assign w_lsu_ready = (w_free >= c_FW'(1));
    assign w_alu_ready = (w_free >= c_FW'(2)) ||
                         ((w_free >= c_FW'(1)) && !wb.lsu_valid_i);

    // x0 results complete the handshake but are never queued; anything
    // seen during reset is discarded.
    assign w_lsu_push = !rst_i && wb.lsu_valid_i && w_lsu_ready &&
                        (wb.lsu_addr_i != '0);
    assign w_alu_push = !rst_i && wb.alu_valid_i && w_alu_ready &&
                        (wb.alu_addr_i != '0);

    always_comb begin
        w_lsu_entry.addr = wb.lsu_addr_i;
        w_lsu_entry.data = f_load_ext(wb.lsu_funct3_i, wb.lsu_off_i, wb.lsu_data_i);
        w_alu_entry.addr = wb.alu_addr_i;
        w_alu_entry.data = wb.alu_data_i;
    end

    wb_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push0_i (w_lsu_push),
        .entry0_i(w_lsu_entry),
        .push1_i (w_alu_push),
        .entry1_i(w_alu_entry),
        .pop_i   (w_busy),
        .head_o  (w_head),
        .count_o (w_count),
        .valid_o (w_valid),
        .addr_o  (w_addr)
    );

    assign w_busy = (w_count != '0);

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) begin
                w_pending[w_addr[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign wb.alu_ready_o = w_alu_ready;
    assign wb.lsu_ready_o = w_lsu_ready;
    assign wb.rf_we_o     = w_busy;
    assign wb.rf_waddr_o  = w_busy ? w_head.addr : '0;
    assign wb.rf_wdata_o  = w_busy ? w_head.data : '0;
    assign wb.pending_o   = w_pending;
    assign wb.busy_o      = w_busy;

endmodule
`default_nettype wire
